// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: active-low hex encoding and blank pattern.
// Used by sseg_bank and the legacy single-digit sseg.
package sseg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   // Entry n is the active-low pattern for hex digit n, bit0 = segment a.
   localparam logic [15:0][6:0] SEG_LUT = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic seg_t hex2seg(input logic [3:0] hex);
      return SEG_LUT[hex];
   endfunction

   // Change counter width; never zero so CHG_BLINKS=0 still elaborates.
   function automatic int chg_width(input int blinks);
      return (blinks > 0) ? $clog2(blinks + 1) : 1;
   endfunction

endpackage

// File: rtl/sseg_digit_ctl.sv
// One display digit: change-flash counter, blank mux and registered segment output.
// Segments follow the latched nibble one edge later; no handshake, no backpressure.
module sseg_digit_ctl
   import sseg_pkg::*;
#(
   parameter int CHG_BLINKS = 3,
   parameter int CW         = chg_width(CHG_BLINKS)
) (
   input  logic       I_CLK,
   input  logic       I_RST,
   input  logic [3:0] nib,
   input  logic [3:0] old_nib,
   input  logic       load,
   input  logic       tick,
   input  logic       phase,
   input  logic       blank,
   output seg_t       seg,
   output logic       busy
);

   localparam logic [CW-1:0] CHG_MAX = CW'(CHG_BLINKS);

   logic [CW-1:0] chg;
   logic          changed;
   logic          flash;

   assign changed = load && (nib != old_nib);
   assign busy    = (chg != '0);
   assign flash   = busy && phase;

   // A reload on a changed nibble takes priority over the tick decrement.
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         chg <= '0;
         seg <= SEG_BLANK;
      end else begin
         if (changed)
            chg <= CHG_MAX;
         else if (tick && busy)
            chg <= chg - 1'b1;
         seg <= (blank || flash) ? SEG_BLANK : hex2seg(old_nib);
      end
   end

endmodule

// File: rtl/sseg_bank.sv
// Bank of hex seven-segment digits with leading-zero blanking, global blink and change flash.
// O_VALUE updates on the load edge, O_HEX/O_BUSY one edge later; no handshake.
module sseg_bank
   import sseg_pkg::*;
#(
   parameter int DIGITS     = 8,
   parameter int BLINK_BITS = 25,
   parameter int CHG_BLINKS = 3
) (
   input  logic                  I_CLK,
   input  logic                  I_RST,
   input  logic                  I_LOAD,
   input  logic [4*DIGITS-1:0]   I_DATA,
   input  logic                  I_LZB,
   input  logic                  I_BLINK_ALL,
   output logic [7*DIGITS-1:0]   O_HEX,
   output logic [4*DIGITS-1:0]   O_VALUE,
   output logic                  O_BUSY
);

   localparam int CW = chg_width(CHG_BLINKS);

   logic [4*DIGITS-1:0]   val;
   logic [BLINK_BITS-1:0] bcnt;
   logic                  tick;
   logic                  phase;
   logic [DIGITS-1:0]     nz_above;
   logic [DIGITS-1:0]     digit_blank;
   logic [DIGITS-1:0]     digit_busy;

   assign tick    = &bcnt;
   assign phase   = bcnt[BLINK_BITS-1];
   assign O_VALUE = val;

   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         val    <= '0;
         bcnt   <= '0;
         O_BUSY <= 1'b0;
      end else begin
         if (I_LOAD)
            val <= I_DATA;
         bcnt   <= bcnt + 1'b1;
         O_BUSY <= |digit_busy;
      end
   end

   // nz_above[i]: some nibble from i up to the MSB digit is non-zero.
   always_comb begin
      logic acc;
      acc         = 1'b0;
      nz_above    = '0;
      digit_blank = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         acc         = acc | (|val[4*i +: 4]);
         nz_above[i] = acc;
      end
      for (int i = 0; i < DIGITS; i++) begin
         digit_blank[i] = (I_LZB && (i != 0) && !nz_above[i]) || (I_BLINK_ALL && phase);
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      sseg_digit_ctl #(
         .CHG_BLINKS (CHG_BLINKS),
         .CW         (CW)
      ) u_digit (
         .I_CLK   (I_CLK),
         .I_RST   (I_RST),
         .nib     (I_DATA[4*g +: 4]),
         .old_nib (val[4*g +: 4]),
         .load    (I_LOAD),
         .tick    (tick),
         .phase   (phase),
         .blank   (digit_blank[g]),
         .seg     (O_HEX[7*g +: 7]),
         .busy    (digit_busy[g])
      );
   end

endmodule

// File: tb/tb_sseg_bank.sv
// Self-checking bench for sseg_bank (4 digits, 16-cycle blink period, 2 change blinks).
// Reference model tracks edges since reset and applies the display rules arithmetically.
module tb_sseg_bank;

   localparam int D  = 4;
   localparam int BB = 4;
   localparam int CB = 2;
   localparam int PERIOD = 1 << BB;

   logic          I_CLK = 1'b0;
   logic          I_RST = 1'b0;
   logic          I_LOAD = 1'b0;
   logic [15:0]   I_DATA = '0;
   logic          I_LZB = 1'b0;
   logic          I_BLINK_ALL = 1'b0;
   logic [27:0]   O_HEX;
   logic [15:0]   O_VALUE;
   logic          O_BUSY;

   int checks = 0;
   int errors = 0;

   logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference model state
   logic [15:0] m_val;
   int          m_chg [D];
   int          m_n;
   logic [27:0] exp_hex;
   logic        exp_busy;
   logic [15:0] exp_value;

   always #5 I_CLK = ~I_CLK;

   sseg_bank #(.DIGITS(D), .BLINK_BITS(BB), .CHG_BLINKS(CB)) dut (
      .I_CLK       (I_CLK),
      .I_RST       (I_RST),
      .I_LOAD      (I_LOAD),
      .I_DATA      (I_DATA),
      .I_LZB       (I_LZB),
      .I_BLINK_ALL (I_BLINK_ALL),
      .O_HEX       (O_HEX),
      .O_VALUE     (O_VALUE),
      .O_BUSY      (O_BUSY)
   );

   task automatic model_reset();
      m_val     = '0;
      m_n       = 0;
      exp_hex   = {D{7'h7F}};
      exp_busy  = 1'b0;
      exp_value = '0;
      for (int i = 0; i < D; i++) m_chg[i] = 0;
   endtask

   // Outputs after an edge are a function of the state before it.
   task automatic model_edge();
      bit ph, tk, blank, any;
      ph  = (m_n % PERIOD) >= (PERIOD / 2);
      tk  = (m_n % PERIOD) == (PERIOD - 1);
      any = 0;
      for (int i = 0; i < D; i++) begin
         blank = (I_LZB && i > 0 && (m_val >> (4 * i)) == 16'd0)
              || (m_chg[i] != 0 && ph) || (I_BLINK_ALL && ph);
         exp_hex[7*i +: 7] = blank ? 7'h7F : lut[m_val[4*i +: 4]];
         if (m_chg[i] != 0) any = 1;
      end
      exp_busy = any;
      for (int i = 0; i < D; i++) begin
         if (I_LOAD && I_DATA[4*i +: 4] != m_val[4*i +: 4]) m_chg[i] = CB;
         else if (tk && m_chg[i] > 0) m_chg[i] = m_chg[i] - 1;
      end
      if (I_LOAD) m_val = I_DATA;
      exp_value = m_val;
      m_n++;
   endtask

   // One clock: drive inputs, advance model on the edge, return at the falling edge.
   task automatic step(input logic ld, input logic [15:0] d);
      I_LOAD = ld;
      I_DATA = d;
      @(posedge I_CLK);
      model_edge();
      @(negedge I_CLK);
      I_LOAD = 1'b0;
   endtask

   task automatic test_reset();
      I_RST = 1'b1;
      #1;
      checks += 3;
      if (O_HEX !== {D{7'h7F}}) begin errors++; $display("FAIL reset_hex: got %h want %h", O_HEX, {D{7'h7F}}); end
      if (O_VALUE !== 16'h0) begin errors++; $display("FAIL reset_value: got %h want 0", O_VALUE); end
      if (O_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", O_BUSY); end
      @(negedge I_CLK);
      I_RST = 1'b0;
      model_reset();
      I_LZB = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step(1'b0, 16'h0);
         checks += 2;
         if (O_HEX !== 28'h8102040) begin errors++; $display("FAIL idle_zero_hex: got %h want %h", O_HEX, 28'h8102040); end
         if (O_BUSY !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", O_BUSY); end
      end
   endtask

   task automatic test_load_a5();
      I_LZB = 1'b1;
      step(1'b1, 16'h00A5);
      checks++;
      if (O_VALUE !== 16'h00A5) begin errors++; $display("FAIL a5_value: got %h want 00a5", O_VALUE); end
      for (int c = 0; c < 3 * PERIOD; c++) begin
         step(1'b0, 16'h0);
         checks += 3;
         if (O_HEX !== exp_hex) begin errors++; $display("FAIL a5_hex cyc %0d: got %h want %h", c, O_HEX, exp_hex); end
         if (O_BUSY !== exp_busy) begin errors++; $display("FAIL a5_busy cyc %0d: got %b want %b", c, O_BUSY, exp_busy); end
         if (O_HEX[27:14] !== 14'h3FFF) begin errors++; $display("FAIL a5_lzb cyc %0d: got %h want 3fff", c, O_HEX[27:14]); end
      end
      checks++;
      if (O_HEX !== {7'h7F, 7'h7F, 7'h08, 7'h12}) begin errors++; $display("FAIL a5_steady: got %h want %h", O_HEX, {7'h7F, 7'h7F, 7'h08, 7'h12}); end
   endtask

   task automatic test_single_change();
      int waited = 0;
      while (O_BUSY && waited < 100) begin step(1'b0, 16'h0); waited++; end
      checks++;
      if (O_BUSY !== 1'b0) begin errors++; $display("FAIL single_idle_timeout: busy %b want 0", O_BUSY); end
      step(1'b0, 16'h0);
      step(1'b1, 16'h01A5);
      for (int c = 0; c < 3 * PERIOD; c++) begin
         step(1'b0, 16'h0);
         checks += 4;
         if (O_HEX !== exp_hex) begin errors++; $display("FAIL single_hex cyc %0d: got %h want %h", c, O_HEX, exp_hex); end
         if (O_BUSY !== exp_busy) begin errors++; $display("FAIL single_busy cyc %0d: got %b want %b", c, O_BUSY, exp_busy); end
         if (O_HEX[13:0] !== {7'h08, 7'h12}) begin errors++; $display("FAIL single_steady cyc %0d: got %h want %h", c, O_HEX[13:0], {7'h08, 7'h12}); end
         if (O_HEX[20:14] !== 7'h79 && O_HEX[20:14] !== 7'h7F) begin errors++; $display("FAIL single_d2 cyc %0d: got %h want 79/7f", c, O_HEX[20:14]); end
      end
   endtask

   task automatic test_tick_load();
      int waited = 0;
      step(1'b1, 16'h01A4);
      while (!(m_chg[0] == 1 && (m_n % PERIOD) == PERIOD - 1) && waited < 64) begin
         step(1'b0, 16'h0);
         waited++;
      end
      checks++;
      if (waited >= 64) begin errors++; $display("FAIL tick_align_timeout: waited %0d want <64", waited); end
      step(1'b1, 16'h1234);
      for (int c = 0; c < 3 * PERIOD; c++) begin
         step(1'b0, 16'h0);
         checks += 3;
         if (O_HEX !== exp_hex) begin errors++; $display("FAIL tick_hex cyc %0d: got %h want %h", c, O_HEX, exp_hex); end
         if (O_BUSY !== exp_busy) begin errors++; $display("FAIL tick_busy cyc %0d: got %b want %b", c, O_BUSY, exp_busy); end
         if (O_VALUE !== exp_value) begin errors++; $display("FAIL tick_value cyc %0d: got %h want %h", c, O_VALUE, exp_value); end
      end
   endtask

   task automatic test_blink_all();
      int waited = 0;
      I_LZB = 1'b0;
      step(1'b1, 16'hFFFF);
      while (O_BUSY && waited < 100) begin step(1'b0, 16'h0); waited++; end
      step(1'b0, 16'h0);
      I_BLINK_ALL = 1'b1;
      for (int c = 0; c < 2 * PERIOD; c++) begin
         step(1'b0, 16'h0);
         checks += 2;
         if (O_HEX !== exp_hex) begin errors++; $display("FAIL blink_hex cyc %0d: got %h want %h", c, O_HEX, exp_hex); end
         if (O_HEX !== {D{7'h0E}} && O_HEX !== {D{7'h7F}}) begin errors++; $display("FAIL blink_pattern cyc %0d: got %h want all 0e or all 7f", c, O_HEX); end
      end
      I_BLINK_ALL = 1'b0;
      for (int c = 0; c < PERIOD; c++) begin
         step(1'b0, 16'h0);
         checks++;
         if (O_HEX !== {D{7'h0E}}) begin errors++; $display("FAIL blink_off cyc %0d: got %h want %h", c, O_HEX, {D{7'h0E}}); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         logic [15:0] d;
         d = O_VALUE;
         if ($urandom_range(3) == 0) d[4*$urandom_range(3) +: 4] = 4'($urandom);
         if ($urandom_range(7) == 0) d = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(3)));
         if ($urandom_range(19) == 0) I_LZB = ~I_LZB;
         if ($urandom_range(29) == 0) I_BLINK_ALL = ~I_BLINK_ALL;
         step(($urandom_range(3) == 0), d);
         checks += 3;
         if (O_HEX !== exp_hex) begin errors++; $display("FAIL rand_hex cyc %0d: got %h want %h", c, O_HEX, exp_hex); end
         if (O_BUSY !== exp_busy) begin errors++; $display("FAIL rand_busy cyc %0d: got %b want %b", c, O_BUSY, exp_busy); end
         if (O_VALUE !== exp_value) begin errors++; $display("FAIL rand_value cyc %0d: got %h want %h", c, O_VALUE, exp_value); end
      end
      I_BLINK_ALL = 1'b0;
   endtask

   task automatic test_reset_mid_flash();
      I_LZB = 1'b0;
      step(1'b1, 16'h5A5A);
      step(1'b1, 16'hA5A5);
      for (int c = 0; c < 3; c++) step(1'b0, 16'h0);
      #2 I_RST = 1'b1;
      #1;
      checks += 3;
      if (O_HEX !== {D{7'h7F}}) begin errors++; $display("FAIL midrst_hex: got %h want %h", O_HEX, {D{7'h7F}}); end
      if (O_BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", O_BUSY); end
      if (O_VALUE !== 16'h0) begin errors++; $display("FAIL midrst_value: got %h want 0", O_VALUE); end
      @(negedge I_CLK);
      I_RST = 1'b0;
      model_reset();
      for (int c = 0; c < PERIOD; c++) begin
         step(1'b0, 16'h0);
         checks += 3;
         if (O_VALUE !== 16'h0) begin errors++; $display("FAIL postrst_value cyc %0d: got %h want 0", c, O_VALUE); end
         if (O_HEX !== exp_hex) begin errors++; $display("FAIL postrst_hex cyc %0d: got %h want %h", c, O_HEX, exp_hex); end
         if (O_BUSY !== 1'b0) begin errors++; $display("FAIL postrst_busy cyc %0d: got %b want 0", c, O_BUSY); end
      end
   endtask

   initial begin
      model_reset();
      #1;
      test_reset();
      test_load_a5();
      test_single_change();
      test_tick_load();
      test_blink_all();
      test_random();
      test_reset_mid_flash();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
